// File: rtl/rvfi_trace_serializer.sv
// Buffers RVFI retire records in a small FIFO and streams each one out as six
// 32-bit trace words over a valid/ready port, tagging records with a sequence number.
module rvfi_trace_serializer #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rvfi_valid,
  input  logic [31:0] rvfi_insn,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [4:0]  rvfi_rs1_addr,
  input  logic [4:0]  rvfi_rs2_addr,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [31:0] rvfi_mem_addr,
  input  logic [31:0] rvfi_mem_wdata,
  input  logic [3:0]  rvfi_mem_wmask,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [7:0]  drop_count,
  output logic [12:0] seq_num
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  wmask;
    logic [12:0] seq;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } rec_t;

  typedef enum logic {IDLE, SEND} state_t;

  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [12:0]   seq_q, seq_d;
  logic [7:0]    drop_q, drop_d;

  logic full, hs, pop, push, drop;
  rec_t head;

  always_comb begin
    full = (count_q == (AW+1)'(DEPTH));
    hs   = (state_q == SEND) && out_ready;
    pop  = hs && (idx_q == 3'd5);
    // A full FIFO still accepts a retire when the head leaves in the same cycle.
    push = rvfi_valid && (!full || pop);
    drop = rvfi_valid && full && !pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    idx_d    = idx_q;
    seq_d    = seq_q;
    drop_d   = drop_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{pc: rvfi_pc_rdata, insn: rvfi_insn, rd: rvfi_rd_addr,
                          rs1: rvfi_rs1_addr, rs2: rvfi_rs2_addr, wmask: rvfi_mem_wmask,
                          seq: seq_q, rd_wdata: rvfi_rd_wdata, mem_addr: rvfi_mem_addr,
                          mem_wdata: rvfi_mem_wdata};
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

    if (rvfi_valid) seq_d = seq_q + 13'd1;
    if (drop && drop_q != 8'hff) drop_d = drop_q + 8'd1;

    if (pop)     idx_d = 3'd0;
    else if (hs) idx_d = idx_q + 3'd1;

    // Entering SEND on the push edge itself gives W0 the cycle after capture.
    state_d = (count_d != '0) ? SEND : IDLE;
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      seq_q    <= 13'd0;
      drop_q   <= 8'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_valid = (state_q == SEND);
    out_last  = out_valid && (idx_q == 3'd5);
    out_data  = 32'd0;
    if (out_valid) begin
      case (idx_q)
        3'd0:    out_data = head.pc;
        3'd1:    out_data = head.insn;
        3'd2:    out_data = {head.rd, head.rs1, head.rs2, head.wmask, head.seq};
        3'd3:    out_data = head.rd_wdata;
        3'd4:    out_data = head.mem_addr;
        3'd5:    out_data = head.mem_wdata;
        default: out_data = 32'd0;
      endcase
    end
    drop_count = drop_q;
    seq_num    = seq_q;
  end

endmodule
